ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter; the send side of the keyboard link that the ps2_Main receiver reads.
//  Sends one command byte to the keyboard over the open-drain PS2_CLK/PS2_DAT pair.
//  Example commands: 0xED set-LEDs, 0xF4 enable, 0xFF reset.
//  Runs the inhibit/request-to-send sequence, shifts out data+parity+stop on device clocks, checks the device ACK.
//  Sits beside ps2_Main; the top level ties *_oe to the inout pads and must mute ps2_Main while busy=1.
// PARAMETERS
//  INHIBIT_CYCLES       5000    clk cycles PS2_CLK held low before request (100us @50MHz)
//  START_TIMEOUT_CYCLES 750000  max cycles from clock release to first device falling edge (15ms)
//  BIT_TIMEOUT_CYCLES   100000  max cycles between consecutive device falling edges / to idle (2ms)
// PORTS
//  clk         in   1  system clock (50MHz)
//  reset       in   1  asynchronous, active-high reset
//  tx_valid    in   1  command byte available
//  tx_data     in   8  command byte, LSB sent first
//  tx_ready    out  1  1 = block idle, will accept tx_valid
//  tx_done     out  1  1-cycle pulse: byte sent and ACK received
//  tx_error    out  1  1-cycle pulse: timeout or NAK
//  busy        out  1  1 from accept until tx_done/tx_error
//  ps2_clk_in  in   1  pad value of PS2_CLK (async)
//  ps2_dat_in  in   1  pad value of PS2_DAT (async)
//  ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release (Z)
//  ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release (Z)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1, counters=0.
//  - ps2_clk_in/ps2_dat_in pass through 2-FF synchronisers. fall = synced clk 1->0 (registered compare, 3-cycle latency).
//  - Handshake: accept when tx_valid&&tx_ready. tx_data latched with odd parity p=~^tx_data. tx_ready=0 the next cycle.
//  - tx_valid while not ready is ignored (not queued).
//  - IDLE: both oe=0. On accept go INHIBIT, ps2_clk_oe=1, timer cleared.
//  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES. In the last cycle set dat_oe=1 (start bit 0), then go REQ.
//  - REQ: clk_oe=0, dat_oe=1, bit index=0. Wait for fall; timer > START_TIMEOUT_CYCLES -> ERR.
//  - SHIFT: on each fall drive the next bit (dat_oe = ~bit).
//    Falls 1..8 = data[0..7], fall 9 = parity, fall 10 = stop (dat_oe=0).
//    Timer reset on every fall; > BIT_TIMEOUT_CYCLES between falls -> ERR.
//  - ACK: on fall 11 sample synced dat. 0 -> WAIT_IDLE, 1 (NAK) -> ERR. Same timeout as SHIFT.
//  - WAIT_IDLE: wait until synced clk=1 and dat=1. Then tx_done=1 for one cycle and go IDLE.
//    Timeout BIT_TIMEOUT_CYCLES -> ERR.
//  - ERR: both oe=0 immediately, tx_error=1 for one cycle, go IDLE. tx_done and tx_error never assert together.
//  - busy = state != IDLE. tx_ready = state == IDLE.
//  - Timer width = $clog2(max(parameters)+1); it saturates and never wraps.
//  - oe outputs are registered (glitch-free pads). Only release (oe=0) in ERR/reset is allowed same-edge.
//  - Device pulling clk low during INHIBIT is ignored; the host owns the line.
//  - Reset mid-transfer: lines released at once, no tx_done/tx_error pulse.
// TESTING
//  - tx_data=0xED, device model clocks at 12.5kHz and ACKs.
//    -> clk low >=5000 cyc; bits 1,0,1,1,0,1,1,1, parity 1, stop 1; then tx_done once; tx_ready back to 1.
//  - tx_data=0xF4 -> parity bit 0, tx_done; a second tx_valid held during the transfer is accepted only after IDLE.
//  - Device never clocks after request -> tx_error at 750000 cyc after clock release; both oe=0.
//  - Device stops after fall 5 -> tx_error 100000 cyc after the last fall; no tx_done.
//  - Device leaves dat high on fall 11 (NAK) -> tx_error pulse; tx_done stays 0.
//  - Assert reset during SHIFT (after fall 4) -> oe=0 asynchronously, tx_ready=1, no pulses; a next 0xFF send completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit, request-to-send, shift data+parity+stop on device clocks, then check the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_error_o,
    output logic       busy_o,
    input  logic       ps2_clk_in_i,
    input  logic       ps2_dat_in_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o
);

    localparam int MAX_AB     = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > BIT_TIMEOUT_CYCLES) ? MAX_AB : BIT_TIMEOUT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [TIMER_W-1:0] INH_PRE   = TIMER_W'(INHIBIT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] INH_LAST  = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LIM = TIMER_W'(START_TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] BIT_LIM   = TIMER_W'(BIT_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_ERR
    } state_t;

    state_t               state_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [9:0]           frame_q;
    logic [3:0]           bit_idx_q;
    logic                 clk_meta_q, clk_sync_q, clk_prev_q, fall_q;
    logic                 dat_meta_q, dat_sync_q;
    logic                 clk_oe_q, dat_oe_q, tx_done_q, tx_error_q;

    // Saturating increment: a stuck line must never wrap the timer back below a limit.
    always_comb begin
        timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            frame_q    <= '0;
            bit_idx_q  <= '0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk_in_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            fall_q     <= clk_prev_q & ~clk_sync_q;
            dat_meta_q <= ps2_dat_in_i;
            dat_sync_q <= dat_meta_q;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            timer_q    <= timer_d;

            case (state_q)
                S_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    timer_q  <= '0;
                    if (tx_valid_i) begin
                        frame_q  <= {1'b1, ~^tx_data_i, tx_data_i};
                        clk_oe_q <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Start bit goes low one cycle before the clock is released.
                    if (timer_q == INH_PRE) begin
                        dat_oe_q <= 1'b1;
                    end
                    if (timer_q == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b1;
                        bit_idx_q <= '0;
                        timer_q   <= '0;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ, S_SHIFT: begin
                    if (fall_q) begin
                        dat_oe_q  <= ~frame_q[bit_idx_q];
                        bit_idx_q <= bit_idx_q + 4'd1;
                        timer_q   <= '0;
                        state_q   <= (bit_idx_q == 4'd9) ? S_ACK : S_SHIFT;
                    end else if (timer_q >= ((state_q == S_REQ) ? START_LIM : BIT_LIM)) begin
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        tx_error_q <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_ACK: begin
                    if (fall_q && !dat_sync_q) begin
                        timer_q <= '0;
                        state_q <= S_WAIT_IDLE;
                    end else if (fall_q || timer_q >= BIT_LIM) begin
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        tx_error_q <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_sync_q && dat_sync_q) begin
                        tx_done_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (timer_q >= BIT_LIM) begin
                        tx_error_q <= 1'b1;
                        state_q    <= S_ERR;
                    end
                end
                S_ERR: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o   = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign tx_done_o    = tx_done_q;
    assign tx_error_o   = tx_error_q;
    assign ps2_clk_oe_o = clk_oe_q;
    assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int STO  = 400;
    localparam int BTO  = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_error, busy, clk_oe, dat_oe;
    logic       dev_clk_pull = 1'b0;
    logic       dev_dat_pull = 1'b0;
    logic       clk_line, dat_line;

    assign clk_line = ~(clk_oe | dev_clk_pull);
    assign dat_line = ~(dat_oe | dev_dat_pull);

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(STO),
        .BIT_TIMEOUT_CYCLES  (BTO)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
        .tx_ready_o  (tx_ready),
        .tx_done_o   (tx_done),
        .tx_error_o  (tx_error),
        .busy_o      (busy),
        .ps2_clk_in_i(clk_line),
        .ps2_dat_in_i(dat_line),
        .ps2_clk_oe_o(clk_oe),
        .ps2_dat_oe_o(dat_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
    int n_checks = 0, n_errors = 0;
    int last_fall = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
        if (tx_valid && tx_ready) acc_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #1 tx_valid = 1'b1;
        tx_data = d;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Device side: waits for the request, then clocks nfalls bits, sampling data on each rise.
    task automatic device(input int nfalls, input bit nak, output logic [9:0] bits,
                          output int inh, output bit req_ok);
        int t;
        bits   = '1;
        inh    = 0;
        req_ok = 1'b0;
        t      = 0;
        @(negedge clk);
        while (!clk_oe && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (clk_oe && inh < 5 * INH) begin
            inh++;
            @(negedge clk);
        end
        req_ok = !clk_oe && dat_oe;
        repeat (HALF) @(posedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_pull = 1'b1;
            last_fall    = cyc;
            if (k == 11 && !nak) dev_dat_pull = 1'b1;
            repeat (HALF) @(posedge clk);
            dev_clk_pull = 1'b0;
            if (k <= 10) bits[k-1] = dat_line;
            repeat (HALF) @(posedge clk);
            if (k == 11) dev_dat_pull = 1'b0;
        end
    endtask

    task automatic wait_evt(input int base, input int budget, output int waited);
        waited = 0;
        while ((done_cnt + err_cnt) == base && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    logic [9:0] bits;
    int inh, waited, d0, e0, a0, t;
    bit req_ok;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", int'(tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_clk_oe", int'(clk_oe), 0);
        check("rst_dat_oe", int'(dat_oe), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_error", int'(tx_error), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 0xED: full transfer with ACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        device(11, 1'b0, bits, inh, req_ok);
        wait_evt(d0 + e0, 200, waited);
        check("ed_inhibit_len", int'(inh >= INH && inh <= INH + 2), 1);
        check("ed_req", int'(req_ok), 1);
        check("ed_data", int'(bits[7:0]), 8'hED);
        check("ed_parity", int'(bits[8]), 1);
        check("ed_stop", int'(bits[9]), 1);
        check("ed_done", done_cnt - d0, 1);
        check("ed_err", err_cnt - e0, 0);
        @(negedge clk);
        check("ed_ready_back", int'(tx_ready), 1);

        // 0xF4 with tx_valid held; next byte 0x12 only accepted once idle
        d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
        @(posedge clk);
        #1 tx_valid = 1'b1;
        tx_data = 8'hF4;
        @(posedge clk);
        #1 tx_data = 8'h12;
        device(11, 1'b0, bits, inh, req_ok);
        check("f4_held_accepts", acc_cnt - a0, 1);
        wait_evt(d0 + e0, 200, waited);
        check("f4_data", int'(bits[7:0]), 8'hF4);
        check("f4_parity", int'(bits[8]), 0);
        check("f4_done", done_cnt - d0, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check("f4_second_accept", acc_cnt - a0, 2);
        d0 = done_cnt;
        device(11, 1'b0, bits, inh, req_ok);
        wait_evt(d0 + err_cnt, 200, waited);
        check("b12_data", int'(bits[7:0]), 8'h12);
        check("b12_parity", int'(bits[8]), 1);
        check("b12_done", done_cnt - d0, 1);

        // Device never clocks: start timeout
        d0 = done_cnt; e0 = err_cnt;
        send(8'hAA);
        t = 0;
        @(negedge clk);
        while (clk_oe && t < 5 * INH) begin
            @(negedge clk);
            t++;
        end
        wait_evt(d0 + e0, 4 * STO, waited);
        check("sto_time", int'(waited >= STO && waited <= STO + 6), 1);
        check("sto_err", err_cnt - e0, 1);
        check("sto_done", done_cnt - d0, 0);
        check("sto_clk_oe", int'(clk_oe), 0);
        check("sto_dat_oe", int'(dat_oe), 0);

        // Device stops after fall 5: bit timeout
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        device(5, 1'b0, bits, inh, req_ok);
        wait_evt(d0 + e0, 4 * BTO, waited);
        check("bto_time", int'((cyc - last_fall) >= BTO && (cyc - last_fall) <= BTO + 10), 1);
        check("bto_err", err_cnt - e0, 1);
        check("bto_done", done_cnt - d0, 0);

        // NAK on fall 11
        d0 = done_cnt; e0 = err_cnt;
        send(8'h55);
        device(11, 1'b1, bits, inh, req_ok);
        wait_evt(d0 + e0, 200, waited);
        repeat (10) @(negedge clk);
        check("nak_data", int'(bits[7:0]), 8'h55);
        check("nak_err", err_cnt - e0, 1);
        check("nak_done", done_cnt - d0, 0);

        // Reset during SHIFT after fall 4
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00);
        device(4, 1'b0, bits, inh, req_ok);
        check("rst_mid_dat_driven", int'(dat_oe), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_clk_oe", int'(clk_oe), 0);
        check("rst_mid_dat_oe", int'(dat_oe), 0);
        check("rst_mid_ready", int'(tx_ready), 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF);
        device(11, 1'b0, bits, inh, req_ok);
        wait_evt(d0 + e0, 200, waited);
        check("ff_data", int'(bits[7:0]), 8'hFF);
        check("ff_parity", int'(bits[8]), 1);
        check("ff_done", done_cnt - d0, 1);
        check("ff_err", err_cnt - e0, 0);

        check("done_err_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
